// File: rtl/mult_acc_stage.sv
// mult_acc_stage: registers 4-bit operand pairs into the combinational 4x4
// multiplier "main" (3:2 carry-save tree plus Kogge-Stone prefix adder),
// then accumulates the products of one packet and holds the result until the
// consumer takes it.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operand beat handshake
//   in_x, in_y, in_last      operands and end-of-packet marker
//   out_valid/out_ready      result handshake
//   out_sum, out_count       packet sum of products and beat count
//   out_ovf                  accumulation overflowed (saturating build only)
//
// Build option: define MULT_ACC_SAT_EN to clamp the accumulator at its maximum
// and report a sticky overflow flag; otherwise the accumulator wraps.
module mult_acc_stage #(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_x,
  input  logic [3:0]       in_y,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam int unsigned PROD_W = 8;
  localparam int unsigned IDX_W  = $clog2(PROD_W);
  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_ACCUM = 2'd0,
    S_FLUSH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;
  logic   r_in_ready, w_in_ready_nxt;
  logic   r_out_valid, w_out_valid_nxt;
  logic   w_accept;

  logic [3:0]        r_x, r_y;
  logic              r_last, r_v1;
  logic [ACC_W-1:0]  r_acc, w_acc_nxt, r_out_sum;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, r_out_count;

  logic [PROD_W-1:0] w_row0, w_row1, w_row2, w_row3;
  logic [PROD_W-1:0] w_s1, w_c1, w_s2, w_c2, w_h, w_g, w_t, w_p;

  assign w_accept = in_valid & r_in_ready;

  // Packet control: accept beats, one flush cycle, then hold the result.
  always_comb begin
    w_state_nxt     = r_state;
    w_in_ready_nxt  = 1'b0;
    w_out_valid_nxt = 1'b0;
    unique case (r_state)
      S_ACCUM: if (w_accept && in_last) w_state_nxt = S_FLUSH;
      S_FLUSH: w_state_nxt = S_HOLD;
      S_HOLD:  if (out_ready) w_state_nxt = S_ACCUM;
      default: w_state_nxt = S_ACCUM;
    endcase
    w_in_ready_nxt  = (w_state_nxt == S_ACCUM);
    w_out_valid_nxt = (w_state_nxt == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_ACCUM;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  // 4x4 multiplier: partial-product rows, two 3:2 compressor layers, prefix adder.
  always_comb begin : main
    w_row0 = r_y[0] ? PROD_W'(r_x)          : '0;
    w_row1 = r_y[1] ? PROD_W'({r_x, 1'b0})  : '0;
    w_row2 = r_y[2] ? PROD_W'({r_x, 2'b00}) : '0;
    w_row3 = r_y[3] ? PROD_W'({r_x, 3'b000}): '0;
    w_s1 = w_row0 ^ w_row1 ^ w_row2;
    w_c1 = ((w_row0 & w_row1) | (w_row0 & w_row2) | (w_row1 & w_row2)) << 1;
    w_s2 = w_s1 ^ w_c1 ^ w_row3;
    w_c2 = ((w_s1 & w_c1) | (w_s1 & w_row3) | (w_c1 & w_row3)) << 1;
    w_g  = w_s2 & w_c2;
    w_t  = w_s2 ^ w_c2;
    w_h  = w_t;
    // Descending bit order lets each level update in place from old lower bits.
    for (int d = 1; d < int'(PROD_W); d = d * 2) begin
      for (int i = int'(PROD_W) - 1; i >= d; i--) begin
        w_g[IDX_W'(i)] = w_g[IDX_W'(i)] | (w_t[IDX_W'(i)] & w_g[IDX_W'(i - d)]);
        w_t[IDX_W'(i)] = w_t[IDX_W'(i)] & w_t[IDX_W'(i - d)];
      end
    end
    // Product never exceeds 8 bits, so the dropped carries are always zero.
    w_p = w_h ^ {w_g[PROD_W-2:0], 1'b0};
  end

  assign w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

`ifdef MULT_ACC_SAT_EN
  logic             r_ovf, r_out_ovf, w_ovf_nxt;
  logic [SUM_W-1:0] w_sum;

  // Once the packet has overflowed the accumulator stays pinned at max.
  assign w_sum     = {1'b0, r_acc} + SUM_W'(w_p);
  assign w_ovf_nxt = r_ovf | w_sum[ACC_W];
  assign w_acc_nxt = w_ovf_nxt ? '1 : w_sum[ACC_W-1:0];
  assign out_ovf   = r_out_ovf;
`else
  assign w_acc_nxt = r_acc + ACC_W'(w_p);
  assign out_ovf   = 1'b0;
`endif

  // Operand register and accumulator; the last beat publishes and clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x         <= '0;
      r_y         <= '0;
      r_last      <= 1'b0;
      r_v1        <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_sum   <= '0;
      r_out_count <= '0;
`ifdef MULT_ACC_SAT_EN
      r_ovf       <= 1'b0;
      r_out_ovf   <= 1'b0;
`endif
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_x    <= in_x;
        r_y    <= in_y;
        r_last <= in_last;
      end
      if (r_v1) begin
        if (r_last) begin
          r_out_sum   <= w_acc_nxt;
          r_out_count <= w_cnt_nxt;
          r_acc       <= '0;
          r_cnt       <= '0;
`ifdef MULT_ACC_SAT_EN
          r_out_ovf   <= w_ovf_nxt;
          r_ovf       <= 1'b0;
`endif
        end else begin
          r_acc <= w_acc_nxt;
          r_cnt <= w_cnt_nxt;
`ifdef MULT_ACC_SAT_EN
          r_ovf <= w_ovf_nxt;
`endif
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;

endmodule

// File: tb/tb_mult_acc_stage.sv
// Bench for mult_acc_stage: three instances (default, ACC_W=8, CNT_W=2) share
// one input stream; each packet result is compared with a packet-level model.
module tb_mult_acc_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [3:0]  in_x = 4'd0;
  logic [3:0]  in_y = 4'd0;

  logic        a_in_ready, a_out_valid, a_out_ovf;
  logic [15:0] a_out_sum;
  logic [7:0]  a_out_count;
  logic        b_in_ready, b_out_valid, b_out_ovf;
  logic [7:0]  b_out_sum;
  logic [7:0]  b_out_count;
  logic        c_in_ready, c_out_valid, c_out_ovf;
  logic [15:0] c_out_sum;
  logic [1:0]  c_out_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] q_x[$];
  logic [3:0] q_y[$];

  longint e_sum_a, e_cnt_a, e_sum_b, e_cnt_b, e_sum_c, e_cnt_c;
  bit     e_ovf_a, e_ovf_b, e_ovf_c;

  logic [15:0] cap_a_sum;
  logic [7:0]  cap_a_cnt;
  logic        cap_a_ovf;
  logic [7:0]  cap_b_sum;
  logic [7:0]  cap_b_cnt;
  logic        cap_b_ovf;
  logic [15:0] cap_c_sum;
  logic [1:0]  cap_c_cnt;

  mult_acc_stage dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_x(in_x), .in_y(in_y), .in_last(in_last), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_sum(a_out_sum), .out_count(a_out_count),
    .out_ovf(a_out_ovf)
  );

  mult_acc_stage #(.ACC_W(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_x(in_x), .in_y(in_y), .in_last(in_last), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_sum(b_out_sum), .out_count(b_out_count),
    .out_ovf(b_out_ovf)
  );

  mult_acc_stage #(.CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_x(in_x), .in_y(in_y), .in_last(in_last), .out_valid(c_out_valid),
    .out_ready(out_ready), .out_sum(c_out_sum), .out_count(c_out_count),
    .out_ovf(c_out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packet-level reference: sum of x*y, clamped or wrapped, count saturated.
  function automatic void model(input int acc_w, input int cnt_w,
                                output longint sum, output longint cnt, output bit ovf);
    longint maxv;
    longint cmax;
    maxv = (longint'(1) << acc_w) - 1;
    cmax = (longint'(1) << cnt_w) - 1;
    sum  = 0;
    ovf  = 1'b0;
    foreach (q_x[i]) begin
      sum = sum + longint'(q_x[i]) * longint'(q_y[i]);
`ifdef MULT_ACC_SAT_EN
      if (sum > maxv) begin
        sum = maxv;
        ovf = 1'b1;
      end
`endif
    end
`ifndef MULT_ACC_SAT_EN
    sum = sum % (maxv + 1);
`endif
    cnt = longint'(q_x.size());
    if (cnt > cmax) cnt = cmax;
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_beats(input bit with_last);
    for (int i = 0; i < q_x.size(); i++) begin
      int guard;
      in_valid = 1'b1;
      in_x     = q_x[i];
      in_y     = q_y[i];
      in_last  = with_last && (i == q_x.size() - 1);
      guard    = 0;
      while (a_in_ready !== 1'b1 && guard < 20) begin
        tick();
        guard++;
      end
      if (guard >= 20) begin
        n_tests++; n_fail++;
        $display("FAIL accept_timeout got in_ready=%b want 1", a_in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_packet(input string name, input int hold);
    int lat;
    model(16, 8, e_sum_a, e_cnt_a, e_ovf_a);
    model(8,  8, e_sum_b, e_cnt_b, e_ovf_b);
    model(16, 2, e_sum_c, e_cnt_c, e_ovf_c);
    out_ready = (hold == 0);
    send_beats(1'b1);
    n_tests++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_flush got in_ready=%b out_valid=%b want 0 0", name, a_in_ready, a_out_valid);
    end
    lat = 1;
    tick();
    while (a_out_valid !== 1'b1 && lat < 6) begin
      tick();
      lat++;
    end
    n_tests++;
    if (a_out_valid !== 1'b1 || lat != 1) begin
      n_fail++;
      $display("FAIL %s_latency got %0d edges (valid=%b) want 1", name, lat, a_out_valid);
    end
    cap_a_sum = a_out_sum; cap_a_cnt = a_out_count; cap_a_ovf = a_out_ovf;
    cap_b_sum = b_out_sum; cap_b_cnt = b_out_count; cap_b_ovf = b_out_ovf;
    cap_c_sum = c_out_sum; cap_c_cnt = c_out_count;
    n_tests++;
    if ({a_out_sum, a_out_count, a_out_ovf} !== {16'(e_sum_a), 8'(e_cnt_a), e_ovf_a}) begin
      n_fail++;
      $display("FAIL %s_a got sum=%0d cnt=%0d ovf=%b want sum=%0d cnt=%0d ovf=%b",
               name, a_out_sum, a_out_count, a_out_ovf, e_sum_a, e_cnt_a, e_ovf_a);
    end
    n_tests++;
    if ({b_out_valid, b_out_sum, b_out_count, b_out_ovf} !== {1'b1, 8'(e_sum_b), 8'(e_cnt_b), e_ovf_b}) begin
      n_fail++;
      $display("FAIL %s_b got valid=%b sum=%0d cnt=%0d ovf=%b want 1 sum=%0d cnt=%0d ovf=%b",
               name, b_out_valid, b_out_sum, b_out_count, b_out_ovf, e_sum_b, e_cnt_b, e_ovf_b);
    end
    n_tests++;
    if ({c_out_valid, c_out_sum, c_out_count, c_out_ovf} !== {1'b1, 16'(e_sum_c), 2'(e_cnt_c), e_ovf_c}) begin
      n_fail++;
      $display("FAIL %s_c got valid=%b sum=%0d cnt=%0d ovf=%b want 1 sum=%0d cnt=%0d ovf=%b",
               name, c_out_valid, c_out_sum, c_out_count, c_out_ovf, e_sum_c, e_cnt_c, e_ovf_c);
    end
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_x     = 4'($urandom);
      in_y     = 4'($urandom);
      in_last  = 1'b0;
      tick();
      n_tests++;
      if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_out_sum !== cap_a_sum ||
          a_out_count !== cap_a_cnt || b_out_sum !== cap_b_sum || b_out_count !== cap_b_cnt) begin
        n_fail++;
        $display("FAIL %s_hold got valid=%b ready=%b sum=%0d cnt=%0d want 1 0 sum=%0d cnt=%0d",
                 name, a_out_valid, a_in_ready, a_out_sum, a_out_count, cap_a_sum, cap_a_cnt);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    n_tests++;
    if ({a_out_valid, b_out_valid, c_out_valid, a_in_ready, b_in_ready, c_in_ready} !== 6'b000111) begin
      n_fail++;
      $display("FAIL %s_release got valid=%b%b%b ready=%b%b%b want 000 111", name,
               a_out_valid, b_out_valid, c_out_valid, a_in_ready, b_in_ready, c_in_ready);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs got in_ready=%b out_valid=%b want 1 0", a_in_ready, a_out_valid);
    end
    n_tests++;
    if (a_out_sum !== 16'd0 || a_out_count !== 8'd0 || a_out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out got sum=%0d cnt=%0d ovf=%b want 0 0 0", a_out_sum, a_out_count, a_out_ovf);
    end
    tick();
    n_tests++;
    if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0 || c_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle got valid=%b%b%b want 000", a_out_valid, b_out_valid, c_out_valid);
    end
  endtask

  task automatic test_basic();
    q_x = '{4'd3, 4'd15, 4'd2};
    q_y = '{4'd5, 4'd15, 4'd7};
    run_packet("basic", 0);
    n_tests++;
    if (cap_a_sum !== 16'd254 || cap_a_cnt !== 8'd3 || cap_a_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_const got sum=%0d cnt=%0d ovf=%b want 254 3 0", cap_a_sum, cap_a_cnt, cap_a_ovf);
    end
  endtask

  task automatic test_single();
    q_x = '{4'd15};
    q_y = '{4'd15};
    run_packet("single", 0);
    n_tests++;
    if (cap_a_sum !== 16'd225 || cap_a_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL single_const got sum=%0d cnt=%0d want 225 1", cap_a_sum, cap_a_cnt);
    end
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        q_x = '{4'(x)};
        q_y = '{4'(y)};
        run_packet("sweep", 0);
        n_tests++;
        if (cap_a_sum !== 16'(x * y)) begin
          n_fail++;
          $display("FAIL sweep_prod got %0d want %0d (x=%0d y=%0d)", cap_a_sum, x * y, x, y);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    q_x = '{4'd9, 4'd6};
    q_y = '{4'd11, 4'd3};
    run_packet("bp", 5);
    q_x = '{4'd1};
    q_y = '{4'd1};
    run_packet("bp_next", 0);
    n_tests++;
    if (cap_a_sum !== 16'd1 || cap_a_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL bp_noconsume got sum=%0d cnt=%0d want 1 1", cap_a_sum, cap_a_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    q_x = '{4'd4, 4'd4};
    q_y = '{4'd4, 4'd4};
    send_beats(1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (a_out_valid !== 1'b0) seen++;
      tick();
    end
    n_tests++;
    if (seen != 0 || a_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_quiet got valid_cycles=%0d ready=%b want 0 1", seen, a_in_ready);
    end
    q_x = '{4'd1};
    q_y = '{4'd1};
    run_packet("after_abort", 0);
    n_tests++;
    if (cap_a_sum !== 16'd1 || cap_a_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL abort_next got sum=%0d cnt=%0d want 1 1", cap_a_sum, cap_a_cnt);
    end
  endtask

  task automatic test_reset_hold();
    q_x = '{4'd7};
    q_y = '{4'd9};
    out_ready = 1'b0;
    send_beats(1'b1);
    tick();
    n_tests++;
    if (a_out_valid !== 1'b1 || a_out_sum !== 16'd63) begin
      n_fail++;
      $display("FAIL hold_pre got valid=%b sum=%0d want 1 63", a_out_valid, a_out_sum);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    n_tests++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_sum !== 16'd0) begin
      n_fail++;
      $display("FAIL hold_drop got valid=%b ready=%b sum=%0d want 0 1 0", a_out_valid, a_in_ready, a_out_sum);
    end
  endtask

  task automatic test_overflow();
    q_x = '{4'd15, 4'd15};
    q_y = '{4'd15, 4'd15};
    run_packet("ovf", 0);
    n_tests++;
`ifdef MULT_ACC_SAT_EN
    if (cap_b_sum !== 8'd255 || cap_b_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_const got sum=%0d ovf=%b want 255 1", cap_b_sum, cap_b_ovf);
    end
`else
    if (cap_b_sum !== 8'd194 || cap_b_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_const got sum=%0d ovf=%b want 194 0", cap_b_sum, cap_b_ovf);
    end
`endif
    q_x = '{4'd1};
    q_y = '{4'd2};
    run_packet("ovf_next", 0);
    n_tests++;
    if (cap_b_sum !== 8'd2 || cap_b_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_next_const got sum=%0d ovf=%b want 2 0", cap_b_sum, cap_b_ovf);
    end
  endtask

  task automatic test_count_sat();
    q_x = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    q_y = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    run_packet("cntsat", 0);
    n_tests++;
    if (cap_c_cnt !== 2'd3 || cap_c_sum !== 16'd5) begin
      n_fail++;
      $display("FAIL cntsat_const got cnt=%0d sum=%0d want 3 5", cap_c_cnt, cap_c_sum);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      int n;
      n = int'($urandom_range(1, 8));
      q_x.delete();
      q_y.delete();
      for (int i = 0; i < n; i++) begin
        q_x.push_back(4'($urandom));
        q_y.push_back(4'($urandom));
      end
      run_packet("rand", int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_backpressure();
    test_reset_mid();
    test_reset_hold();
    test_overflow();
    test_count_sat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
